aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Iterative AES cipher round sequencer. It holds the 128-bit cipher state and fetches one round key per round from an external key-expansion store over a req/ack handshake. It drives an external combinational round function (SubBytes/ShiftRows/MixColumns) and performs the AddRoundKey XOR internally. It sits between the top-level cipher wrapper and the round datapath, and produces one encrypted block per start.

Parameters:
NK, 4, key length in 32-bit words (4/6/8 for AES-128/192/256); NR = NK+6 rounds, derived locally.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a block; sampled only while busy=0
data_in  input  128  plaintext, captured on the accepted start
busy  output  1  high from the cycle after start is accepted until the final round completes
done  output  1  one-cycle pulse; data_out valid from this cycle
data_out  output  128  ciphertext, held until the next block completes
key_req  output  1  round-key request
key_round  output  4  index of the requested round key (0..NR)
key_ack  input  1  round_key valid for key_round this cycle
round_key  input  128  round key for key_round
rf_in  output  128  current state to the round function (= state register)
rf_last  output  1  high when key_round==NR (round function skips MixColumns)
rf_out  input  128  combinational round-function result for rf_in

Behaviour:
- Reset (asynchronous, active-high): FSM=IDLE; state, data_out, round=0; busy, done, key_req=0. Reset mid-block abandons the block; no done is produced.
- FSM states: IDLE, KEY, DONE.
- IDLE: on start=1, state<=data_in, round<=0, go to KEY.
- KEY: busy=1, key_req=1, key_round=round, rf_last=(round==NR).
  - key_ack=0: hold all registers; key_req stays high, key_round stays stable.
  - key_ack=1 and round==0: state<=state^round_key (initial AddRoundKey).
  - key_ack=1 and round>0: state<=rf_out^round_key.
  - After an ack with round<NR: round<=round+1, stay in KEY.
  - After an ack with round==NR: data_out<=result, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, key_req=0.
  - start=1 in DONE is accepted (state<=data_in, round<=0, go to KEY); otherwise go to IDLE.
- start while busy=1 is ignored and has no side effect.
- key_ack while key_req=0 is ignored.
- Latency with key_ack tied high: start accepted at edge T0; KEY occupies NR+1 cycles; done is high in cycle NR+2 after T0 (AES-128: 12 cycles from start to done). Each deasserted-ack cycle adds one cycle.
- Outputs rf_in, key_round and rf_last are registered or derived only from registers, with no combinational path from inputs. rf_out and round_key are consumed only in the ack cycle.
- round counter is 4 bits, never exceeds NR, and never wraps.
- data_out changes only on the final-round ack edge (or reset).

Test Plan:
- Identity round function (rf_out=rf_in), NK=4, every round key 128'ha0fafe17_88542cb1_23a33939_2a6c7605, key_ack=1, data_in=128'h046681e5_e0cb199a_48f8d37a_2806264c. Required: 11 XORs give data_out=128'ha49c7ff2_689f352b_6b5bea43_026a5049; done exactly 12 cycles after start; key_round sequence 0..10; rf_last only at key_round=10.
- Golden AES round model plus FIPS-197 key schedule, NK=4, key 000102...0f, data_in 00112233445566778899aabbccddeeff. Required: data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- key_ack stalled 3 cycles at key_round=5. Required: key_req and key_round=5 held stable and state unchanged during the stall; done at 15 cycles; same data_out as the ack-high run.
- start pulsed at cycles 3 and 7 while busy. Required: ignored; one done; data_out matches the first block only.
- Reset asserted at key_round=4, then start with new data. Required: immediately busy=0, key_req=0, data_out=0; the next block completes normally with a correct result.
- Back-to-back blocks with start held high in the DONE cycle. Required: second block accepted with no IDLE cycle; two done pulses 12 cycles apart; NK=8 variant gives key_round 0..14 and done at 16 cycles.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: block start/result, round-key fetch and round-function signals of the AES round sequencer
interface aes_round_ctrl_if;
  logic         start;
  logic [127:0] data_in;
  logic         busy;
  logic         done;
  logic [127:0] data_out;
  logic         key_req;
  logic [3:0]   key_round;
  logic         key_ack;
  logic [127:0] round_key;
  logic [127:0] rf_in;
  logic         rf_last;
  logic [127:0] rf_out;
  modport master (
    input  start, data_in, key_ack, round_key, rf_out,
    output busy, done, data_out, key_req, key_round, rf_in, rf_last
  );
  modport slave (
    output start, data_in, key_ack, round_key, rf_out,
    input  busy, done, data_out, key_req, key_round, rf_in, rf_last
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer; fetches one round key per round and applies AddRoundKey
module aes_round_ctrl #(
  parameter int NK = 4
) (
  input logic clk,
  input logic reset,
  aes_round_ctrl_if.master bus
);
  localparam logic [3:0] NR = 4'(NK + 6);
  typedef enum logic [1:0] {IDLE, KEY, DONE} fsm_t;
  fsm_t fsm, fsm_nx;
  logic [127:0] state, state_nx, data_out, data_out_nx, result;
  logic [3:0] round, round_nx;
  // round 0 is the initial AddRoundKey on the raw state
  assign result = (round == 4'd0 ? state : bus.rf_out) ^ bus.round_key;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm      <= IDLE;
      state    <= '0;
      data_out <= '0;
      round    <= '0;
    end else begin
      fsm      <= fsm_nx;
      state    <= state_nx;
      data_out <= data_out_nx;
      round    <= round_nx;
    end
  end
  always_comb begin
    fsm_nx      = fsm;
    state_nx    = state;
    data_out_nx = data_out;
    round_nx    = round;
    case (fsm)
      IDLE, DONE: begin
        fsm_nx = bus.start ? KEY : IDLE;
        if (bus.start) begin
          state_nx = bus.data_in;
          round_nx = '0;
        end
      end
      KEY: if (bus.key_ack) begin
        state_nx = result;
        if (round == NR) begin
          data_out_nx = result;
          fsm_nx      = DONE;
        end else begin
          round_nx = round + 4'd1;
        end
      end
      default: fsm_nx = IDLE;
    endcase
  end
  assign bus.busy      = fsm == KEY;
  assign bus.key_req   = fsm == KEY;
  assign bus.done      = fsm == DONE;
  assign bus.data_out  = data_out;
  assign bus.key_round = round;
  assign bus.rf_in     = state;
  assign bus.rf_last   = round == NR;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: table-driven and randomized check of the AES round sequencer against a FIPS-197 model
module tb_aes_round_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic start, key_ack, ident;
  logic [127:0] data_in;
  logic [127:0] rk4 [16];
  logic [127:0] rk8 [16];
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] IDK = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;

  aes_round_ctrl_if b4 ();
  aes_round_ctrl_if b8 ();
  aes_round_ctrl #(.NK(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  aes_round_ctrl #(.NK(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = xtime(a);
    end
    return r;
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, b;
    p = x;
    b = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      b = gmul(b, p);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last)
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic logic [127:0] rkey(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [255:0] key, input int nk, input logic [127:0] d);
    logic [127:0] s;
    s = d ^ rkey(key, nk, 0);
    for (int r = 1; r <= nk + 6; r++) s = aes_round(s, r == nk + 6) ^ rkey(key, nk, r);
    return s;
  endfunction

  // external key store and round function seen by each sequencer
  assign b4.start     = start;
  assign b8.start     = start;
  assign b4.data_in   = data_in;
  assign b8.data_in   = data_in;
  assign b4.key_ack   = key_ack;
  assign b8.key_ack   = key_ack;
  assign b4.round_key = ident ? IDK : rk4[b4.key_round];
  assign b8.round_key = ident ? IDK : rk8[b8.key_round];
  assign b4.rf_out    = ident ? b4.rf_in : aes_round(b4.rf_in, b4.rf_last);
  assign b8.rf_out    = ident ? b8.rf_in : aes_round(b8.rf_in, b8.rf_last);

  typedef struct {
    logic         id;
    logic [255:0] key;
    logic [127:0] din;
    int           stall_at;
    int           stall_n;
    logic         pulse;
    logic [127:0] exp4;
    logic [127:0] exp8;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_keys(input logic id, input logic [255:0] key);
    ident = id;
    for (int r = 0; r < 16; r++) begin
      rk4[r] = r <= 10 ? rkey(key, 4, r) : '0;
      rk8[r] = r <= 14 ? rkey(key, 8, r) : '0;
    end
  endtask

  task automatic run_block(input vec_t v, input string tag);
    int lat4, lat8, cnt4, cnt8, kr4, kr8, stalled;
    logic seq4, seq8, stall_ok, hold_ok, last_ack;
    logic [3:0] prev_kr;
    logic [127:0] prev_rf, old4, old8;
    load_keys(v.id, v.key);
    lat4 = 0; lat8 = 0; cnt4 = 0; cnt8 = 0; kr4 = 0; kr8 = 0; stalled = 0;
    seq4 = 1; seq8 = 1; stall_ok = 1; hold_ok = 1; last_ack = 1;
    prev_kr = '0; prev_rf = '0;
    @(negedge clk);
    old4 = b4.data_out;
    old8 = b8.data_out;
    start = 1; data_in = v.din; key_ack = 1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (b4.done) begin cnt4++; if (lat4 == 0) lat4 = cyc; end
      if (b8.done) begin cnt8++; if (lat8 == 0) lat8 = cyc; end
      if (lat4 == 0 && b4.data_out !== old4) hold_ok = 0;
      if (lat8 == 0 && b8.data_out !== old8) hold_ok = 0;
      if (!last_ack && (!b4.key_req || b4.key_round !== prev_kr || b4.rf_in !== prev_rf)) stall_ok = 0;
      if (b4.busy) begin
        if (b4.key_round !== 4'(kr4) || b4.rf_last !== (kr4 == 10) || !b4.key_req) seq4 = 0;
      end else if (b4.key_req) seq4 = 0;
      if (b8.busy) begin
        if (b8.key_round !== 4'(kr8) || b8.rf_last !== (kr8 == 14) || !b8.key_req) seq8 = 0;
      end else if (b8.key_req) seq8 = 0;
      start   = v.pulse && (cyc == 3 || cyc == 7);
      data_in = start ? ~v.din : v.din;
      if (b4.busy && b4.key_round == 4'(v.stall_at) && stalled < v.stall_n) begin
        key_ack = 0;
        stalled++;
      end else key_ack = 1;
      if (b4.busy && key_ack) kr4++;
      if (b8.busy && key_ack) kr8++;
      last_ack = key_ack;
      prev_kr  = b4.key_round;
      prev_rf  = b4.rf_in;
      if (lat8 != 0 && cyc >= lat8 + 2) break;
    end
    key_ack = 1;
    check({tag, " lat4"}, 128'(lat4), 128'(12 + v.stall_n));
    check({tag, " lat8"}, 128'(lat8), 128'(16 + v.stall_n));
    check({tag, " done4 pulses"}, 128'(cnt4), 128'd1);
    check({tag, " done8 pulses"}, 128'(cnt8), 128'd1);
    check({tag, " data_out4"}, b4.data_out, v.exp4);
    check({tag, " data_out8"}, b8.data_out, v.exp8);
    check({tag, " rounds4"}, {seq4, 7'(kr4)}, {1'b1, 7'd11});
    check({tag, " rounds8"}, {seq8, 7'(kr8)}, {1'b1, 7'd15});
    check({tag, " stall hold"}, 128'(stall_ok), 128'd1);
    check({tag, " data_out stable"}, 128'(hold_ok), 128'd1);
  endtask

  vec_t tv [10];
  logic [255:0] fk;
  logic [127:0] fd, d1, d2;

  initial begin
    fk = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    fd = 128'h00112233445566778899aabbccddeeff;
    tv[0] = '{1'b1, 256'h0, 128'h046681e5_e0cb199a_48f8d37a_2806264c, -1, 0, 1'b0,
              128'ha49c7ff2_689f352b_6b5bea43_026a5049, 128'ha49c7ff2_689f352b_6b5bea43_026a5049};
    tv[1] = '{1'b0, fk, fd, -1, 0, 1'b0,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h8ea2b7ca516745bfeafc49904b496089};
    tv[2] = '{1'b0, fk, fd, 5, 3, 1'b0,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h8ea2b7ca516745bfeafc49904b496089};
    tv[3] = '{1'b0, fk, fd, -1, 0, 1'b1,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h8ea2b7ca516745bfeafc49904b496089};
    for (int i = 4; i < 10; i++) begin
      tv[i].id = 1'b0;
      tv[i].key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tv[i].din = {$urandom, $urandom, $urandom, $urandom};
      tv[i].stall_at = int'($urandom_range(0, 10));
      tv[i].stall_n = int'($urandom_range(0, 3));
      tv[i].pulse = 1'($urandom_range(0, 1));
      tv[i].exp4 = aes_encrypt(tv[i].key, 4, tv[i].din);
      tv[i].exp8 = aes_encrypt(tv[i].key, 8, tv[i].din);
    end
    reset = 1; start = 0; key_ack = 0; data_in = '0;
    load_keys(1'b0, fk);
    repeat (3) @(negedge clk);
    check("reset busy/done/key_req", {b4.busy, b4.done, b4.key_req, b8.busy}, 4'b0);
    check("reset data_out", b4.data_out, '0);
    check("reset key_round/rf_in", {b4.key_round, b4.rf_in}, '0);
    reset = 0;
    for (int i = 0; i < 10; i++) run_block(tv[i], $sformatf("vec%0d", i));

    // reset in the middle of a block abandons it
    load_keys(1'b0, fk);
    @(negedge clk);
    start = 1; data_in = fd; key_ack = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 30 && b4.key_round != 4'd4; i++) @(negedge clk);
    check("mid-block key_round", 128'(b4.key_round), 128'd4);
    reset = 1;
    #1;
    check("async reset busy/key_req", {b4.busy, b4.key_req, b8.busy, b8.key_req}, 4'b0);
    check("async reset data_out", {b4.data_out, b8.data_out}, '0);
    @(negedge clk);
    reset = 0;
    run_block(tv[5], "after reset");

    // back-to-back: start held through the DONE cycle
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    load_keys(1'b0, fk);
    @(negedge clk);
    start = 1; data_in = d1; key_ack = 1;
    begin
      int first, second;
      first = 0; second = 0;
      for (int cyc = 1; cyc <= 40 && second == 0; cyc++) begin
        @(negedge clk);
        if (first != 0 && cyc == first + 1) begin
          check("b2b no idle gap", 128'(b4.busy), 128'd1);
          start = 0;
        end
        if (b4.done) begin
          if (first == 0) begin
            first = cyc;
            check("b2b first data_out", b4.data_out, aes_encrypt(fk, 4, d1));
            data_in = d2;
          end else second = cyc;
        end
      end
      start = 0;
      check("b2b first done", 128'(first), 128'd12);
      check("b2b done spacing", 128'(second - first), 128'd12);
      check("b2b second data_out", b4.data_out, aes_encrypt(fk, 4, d2));
    end
    repeat (8) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
